dmem_arbiter: RTL

- Two-port arbiter that shares the single data memory between the core load/store unit (port 0) and the debug/program-loader port (port 1).
- Each port uses a valid/ready request handshake. The arbiter grants one request per cycle using round-robin priority and drives the memory's addr/data/read/write/size/unsigned inputs.
- It registers the read result and returns a single-cycle response tagged to the originating port.
- It rejects misaligned, out-of-range and illegal-size accesses with an error response and issues no memory strobe for them.

---
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core LSU (port 0)
// and the debug/loader port (port 1) with round-robin arbitration.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pN_req_*            valid/ready request (we, addr, wdata, size, unsigned)
//   pN_rsp_*            one-cycle response pulse (valid, rdata, err)
//   mem_*               memory strobes; mem_rdata is a combinational read
module dmem_arbiter #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [31:0]       p0_req_wdata,
    input  logic [1:0]        p0_req_size,
    input  logic              p0_req_unsigned,
    output logic              p0_rsp_valid,
    output logic [31:0]       p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [31:0]       p1_req_wdata,
    input  logic [1:0]        p1_req_size,
    input  logic              p1_req_unsigned,
    output logic              p1_rsp_valid,
    output logic [31:0]       p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic              mem_unsigned,
    input  logic [31:0]       mem_rdata
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [1:0]        size;
        logic              uns;
    } req_t;

    // One extra bit so the limit itself is representable.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * MEM_DEPTH);

    logic        rr_ptr;
    logic        gnt0;
    logic        gnt1;
    logic        hs;
    req_t        req;
    logic        err;
    logic        rsp_v;
    logic        rsp_port;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // rr_ptr names the port that wins a tie.
    assign gnt1 = p1_req_valid && (!p0_req_valid || rr_ptr);
    assign gnt0 = p0_req_valid && !gnt1;
    assign hs   = gnt0 || gnt1;

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    always_comb begin
        req = '0;
        unique case (1'b1)
            gnt0: req = {p0_req_we, p0_req_addr, p0_req_wdata,
                         p0_req_size, p0_req_unsigned};
            gnt1: req = {p1_req_we, p1_req_addr, p1_req_wdata,
                         p1_req_size, p1_req_unsigned};
            default: req = '0;
        endcase
    end

    always_comb begin
        err = 1'b0;
        unique case (req.size)
            2'b00:   err = 1'b0;
            2'b01:   err = req.addr[0];
            2'b10:   err = |req.addr[1:0];
            default: err = 1'b1;
        endcase
        if ({1'b0, req.addr} >= ADDR_LIMIT) begin
            err = 1'b1;
        end
        if (!hs) begin
            err = 1'b0;
        end
    end

    assign mem_addr     = req.addr;
    assign mem_wdata    = req.wdata;
    assign mem_size     = req.size;
    assign mem_unsigned = req.uns;
    assign mem_read     = hs && !err && !req.we;
    assign mem_write    = hs && !err && req.we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            rsp_v     <= 1'b0;
            rsp_port  <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_v     <= hs;
            rsp_port  <= gnt1;
            rsp_err   <= err;
            rsp_rdata <= mem_read ? mem_rdata : 32'h0;
            // Favour the loser next time: after a port-0 grant, port 1 wins.
            if (hs) begin
                rr_ptr <= gnt0;
            end
        end
    end

    assign p0_rsp_valid = rsp_v && !rsp_port;
    assign p1_rsp_valid = rsp_v && rsp_port;
    assign p0_rsp_rdata = p0_rsp_valid ? rsp_rdata : 32'h0;
    assign p1_rsp_rdata = p1_rsp_valid ? rsp_rdata : 32'h0;
    assign p0_rsp_err   = p0_rsp_valid && rsp_err;
    assign p1_rsp_err   = p1_rsp_valid && rsp_err;

endmodule
